msrv32_irq_gen: RTL

Interrupt source block for the msrv32 core. It generates the three core interrupt inputs: `ms_riscv32_mp_eirq_in`, `ms_riscv32_mp_tirq_in` and `ms_riscv32_mp_sirq_in`.
- Software interrupt: a memory-mapped MSIP bit.
- Timer interrupt: a 64-bit mtime/mtimecmp pair.
- External interrupt: an edge-latched, maskable aggregator over N asynchronous sources.

Software programs the block through a simple single-cycle register port. The block sits between peripheral interrupt lines and the core's IRQ pins.

---
 rtl/msrv32_irq_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/msrv32_irq_gen.sv
// Interrupt source block for the msrv32 core: MSIP software interrupt, 64-bit mtime/mtimecmp
// timer interrupt, and an edge-latched, maskable external interrupt aggregator.
module msrv32_irq_gen #(
    parameter int unsigned N_EXT    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_n_in,
    input  logic [N_EXT-1:0] ext_src_in,
    input  logic             bus_req_in,
    input  logic             bus_we_in,
    input  logic [4:0]       bus_addr_in,
    input  logic [31:0]      bus_wdata_in,
    output logic [31:0]      bus_rdata_out,
    output logic             bus_ready_out,
    output logic             ms_riscv32_mp_eirq_out,
    output logic             ms_riscv32_mp_tirq_out,
    output logic             ms_riscv32_mp_sirq_out
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [2:0] A_MSIP        = 3'd0;
    localparam logic [2:0] A_MTIME_LO    = 3'd1;
    localparam logic [2:0] A_MTIME_HI    = 3'd2;
    localparam logic [2:0] A_MTIMECMP_LO = 3'd3;
    localparam logic [2:0] A_MTIMECMP_HI = 3'd4;
    localparam logic [2:0] A_EPEND       = 3'd5;
    localparam logic [2:0] A_EEN         = 3'd6;

    logic [PW-1:0]    presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q, msip_d;
    logic [N_EXT-1:0] epend_q, epend_d;
    logic [N_EXT-1:0] een_q, een_d;
    logic [N_EXT-1:0] sync1_q, sync2_q, dly_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q;
    logic             tirq_q, eirq_q, sirq_q;

    logic             tick_c;
    logic             wr_c, rd_c;
    logic [2:0]       widx_c;
    logic [N_EXT-1:0] edge_c;
    logic [N_EXT-1:0] w1c_c;
    logic [31:0]      rdata_c;
    logic             unused_c;

    assign unused_c = ^bus_addr_in[1:0];

    assign tick_c = (presc_q == PW'(PRESCALE - 1));
    assign wr_c   = bus_req_in & bus_we_in;
    assign rd_c   = bus_req_in & ~bus_we_in;
    assign widx_c = bus_addr_in[4:2];
    assign edge_c = sync2_q & ~dly_q;

    // Read mux over current register state; unmapped offsets and unused bits read 0.
    always_comb begin
        rdata_c = '0;
        case (widx_c)
            A_MSIP:        rdata_c = 32'(msip_q);
            A_MTIME_LO:    rdata_c = mtime_q[31:0];
            A_MTIME_HI:    rdata_c = mtime_q[63:32];
            A_MTIMECMP_LO: rdata_c = mtimecmp_q[31:0];
            A_MTIMECMP_HI: rdata_c = mtimecmp_q[63:32];
            A_EPEND:       rdata_c = 32'(epend_q);
            A_EEN:         rdata_c = 32'(een_q);
            default:       rdata_c = '0;
        endcase
    end

    // Next-state: a software write to mtime replaces the whole tick update for that cycle.
    always_comb begin
        presc_d    = tick_c ? '0 : presc_q + PW'(1);
        mtime_d    = tick_c ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        een_d      = een_q;
        w1c_c      = '0;
        rdata_d    = rd_c ? rdata_c : '0;
        if (wr_c) begin
            case (widx_c)
                A_MSIP:        msip_d     = bus_wdata_in[0];
                A_MTIME_LO:    mtime_d    = {mtime_q[63:32], bus_wdata_in};
                A_MTIME_HI:    mtime_d    = {bus_wdata_in, mtime_q[31:0]};
                A_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus_wdata_in};
                A_MTIMECMP_HI: mtimecmp_d = {bus_wdata_in, mtimecmp_q[31:0]};
                A_EPEND:       w1c_c      = bus_wdata_in[N_EXT-1:0];
                A_EEN:         een_d      = bus_wdata_in[N_EXT-1:0];
                default:       ;
            endcase
        end
        // A fresh edge beats a same-cycle clear.
        epend_d = (epend_q & ~w1c_c) | edge_c;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            epend_q    <= '0;
            een_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            dly_q      <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            tirq_q     <= 1'b0;
            eirq_q     <= 1'b0;
            sirq_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            epend_q    <= epend_d;
            een_q      <= een_d;
            sync1_q    <= ext_src_in;
            sync2_q    <= sync1_q;
            dly_q      <= sync2_q;
            rdata_q    <= rdata_d;
            ready_q    <= bus_req_in;
            tirq_q     <= (mtime_q >= mtimecmp_q);
            eirq_q     <= |(epend_q & een_q);
            sirq_q     <= msip_q;
        end
    end

    assign bus_rdata_out          = rdata_q;
    assign bus_ready_out          = ready_q;
    assign ms_riscv32_mp_eirq_out = eirq_q;
    assign ms_riscv32_mp_tirq_out = tirq_q;
    assign ms_riscv32_mp_sirq_out = sirq_q;

endmodule
